// File: rtl/router_port_ctrl.sv
// Port controller for the 1x3 router: latches the header address, steers write
// enable and full flag to the addressed FIFO, and flushes ports whose reader stalls.
module router_port_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2,
  output logic       addr_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0] addr;
  logic [2:0] rd;
  logic [2:0] emp;
  logic [2:0] vld;
  logic [2:0] sr;

  assign rd  = {read_enb_2, read_enb_1, read_enb_0};
  assign emp = {empty_2, empty_1, empty_0};
  assign vld = ~emp;

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  assign soft_reset_0 = sr[0];
  assign soft_reset_1 = sr[1];
  assign soft_reset_2 = sr[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr     <= 2'b00;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      addr     <= data_in;
      addr_err <= (data_in == 2'b11);
    end
  end

  // Address 3 has no FIFO: drop writes and never report full so the packet drains.
  always_comb begin
    write_enb = 3'b000;
    fifo_full = 1'b0;
    case (addr)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
      end
    endcase
  end

  // Stall counters; a pulse also clears the count so pulses never run back-to-back.
  for (genvar g = 0; g < 3; g++) begin : g_port
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt   <= '0;
        sr[g] <= 1'b0;
      end else if (!vld[g] || rd[g] || sr[g]) begin
        cnt   <= '0;
        sr[g] <= 1'b0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        sr[g] <= 1'b1;
      end else begin
        cnt   <= cnt + CW'(1);
        sr[g] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/router_port_ctrl.md
# router_port_ctrl

Port controller for the 1x3 router. It sits between the router FSM and the three output FIFOs. It latches the destination address from the header byte and steers the write enable and the full flag to and from the selected FIFO. It also drives the per-port valid outputs and generates a one-cycle soft reset for any port whose destination stops reading for TIMEOUT consecutive cycles.

## Interface
Parameters:
- TIMEOUT, 30, number of consecutive stalled cycles (vld_out high, read_enb low) before that port's soft reset fires; legal range 2..255.

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- detect_add  in  1  from FSM; latch address on this edge
- data_in  in  2  header address bits [1:0]
- write_enb_reg  in  1  from FSM; a payload byte is being written this cycle
- read_enb_0, read_enb_1, read_enb_2  in  1 each  destination read strobes
- empty_0, empty_1, empty_2  in  1 each  FIFO empty flags
- full_0, full_1, full_2  in  1 each  FIFO full flags
- write_enb  out  3  one-hot FIFO write enable
- fifo_full  out  1  full flag of the addressed FIFO, to FSM
- vld_out_0, vld_out_1, vld_out_2  out  1 each  data-available to destination
- soft_reset_0, soft_reset_1, soft_reset_2  out  1 each  one-cycle FIFO flush pulse
- addr_err  out  1  latched address is 2'b11 (no such port)

## Operation
- Address register addr[1:0]:
  - Reset value 2'b00.
  - On a rising edge with detect_add=1, addr <= data_in.
  - Otherwise addr holds.
  - addr_err <= (data_in==2'b11) on the same edge; it holds until the next detect_add.
- write_enb (combinational):
  - If write_enb_reg=1 and addr<3: write_enb = 1<<addr.
  - Otherwise 3'b000. For addr=3, data is silently dropped.
- fifo_full (combinational):
  - full_0/1/2 selected by addr.
  - 0 when addr=3, so the FSM drains the packet without stalling.
- vld_out_x = ~empty_x (combinational).
- Per-port stall counter cnt_x (width $clog2(TIMEOUT+1)), updated on each rising edge:
  - Clear to 0 if vld_out_x=0, read_enb_x=1, or soft_reset_x=1.
  - Else, if cnt_x==TIMEOUT-1: soft_reset_x <= 1 and cnt_x <= 0.
  - Else cnt_x <= cnt_x+1.
- soft_reset_x is registered:
  - It is high for exactly one cycle, then returns to 0.
  - It never asserts twice back-to-back.
- The three ports are fully independent. Simultaneous timeouts on several ports all fire in the same cycle.

## Timing
- Reset values: addr=0, addr_err=0, all cnt_x=0, soft_reset_0/1/2=0.
  - write_enb=000, since write_enb_reg gates it.
  - fifo_full=full_0, vld_out_x=~empty_x.
- Latency:
  - write_enb, fifo_full and vld_out follow their inputs combinationally, with zero cycles of latency.
  - A new address takes effect one edge after detect_add.
- detect_add and write_enb_reg high in the same cycle: write_enb uses the OLD addr for that cycle.
- Timeout edge: if the stall condition holds for edges 1..TIMEOUT, soft_reset_x rises after edge TIMEOUT and falls after edge TIMEOUT+1.
- read_enb_x=1 on the edge where cnt_x==TIMEOUT-1: no pulse; cnt_x clears.
- FIFO still non-empty after the flush (e.g. concurrent writes): counting restarts from 0 on the edge after the pulse.
- Reset asserted mid-count: cnt_x=0 and soft_reset_x=0 immediately (asynchronous), no pending pulse survives. Counting resumes on the first edge after reset deasserts.
- Reset asserted while soft_reset_x=1: the pulse is cut short immediately.

## Test plan
- Reset: drive empty_0=0 and read_enb_0=0 for 10 cycles, then assert reset. Required: soft_reset_0=0, addr=0 and addr_err=0 at once; a full TIMEOUT=30 stalled cycles are needed after release before soft_reset_0 fires.
- Address steer: pulse detect_add with data_in=2'b01, then write_enb_reg=1 and full_1=1. Required: write_enb=3'b010, fifo_full=1; then toggle full_1=0 and require fifo_full=0 in the same cycle.
- Timeout: empty_2=0 and read_enb_2=0 held from edge 1. Required: soft_reset_2=1 only between edge 30 and edge 31, then 0; soft_reset_0 and soft_reset_1 stay 0.
- Rescue read: as above, but read_enb_2=1 on edge 30. Required: no pulse; a further 29 stalled edges also give no pulse, and the 30th gives a pulse.
- Bad address: detect_add with data_in=2'b11, then write_enb_reg=1 and full_0=full_1=full_2=1. Required: addr_err=1, write_enb=000, fifo_full=0. A following detect_add with data_in=2'b10 clears addr_err.
- Concurrent timeouts: empty_0/1/2=0 with no reads for 30 edges. Required: all three soft_reset outputs pulse in the same cycle, with the same-cycle detect_add/write_enb_reg old-address rule checked alongside.
